mips_wb_arbiter: RTL and testbench

- Single-owner driver of the MIPS register file write port; it is the writer side of the regfile interface.
- Merges two result sources:
  - the in-order pipeline (ALU/load, fixed slot, cannot stall);
  - a long-latency source (mul/div, uncached load) with valid/ready handshake, buffered in a small FIFO.
- Drives registered WriteAddress/RegWrite/DataIn to the register file.
- Guarantees long-latency results are not starved.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mips_wb_fifo.sv | 81 ++++++++
 rtl/mips_wb_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mips_wb_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS writeback path.
//   REG_ADDR_W / XLEN / NUM_REGS : register-file geometry
//   wb_req_t                     : one pending register write {addr, data}
//   wb_starve_state_t            : starvation FSM states of the writeback arbiter
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STALL
  } wb_starve_state_t;

endpackage

// File: rtl/mips_wb_fifo.sv
// Small circular FIFO of pending long-latency register writes.
// Ports:
//   CLK, reset   : clock (rising edge), asynchronous active-high reset
//   push/push_req: enqueue one entry (ignored when full)
//   pop/head     : dequeue head entry (ignored when empty); head is the current oldest entry
//   full/empty   : occupancy flags derived from the registered count
//   entry_valid  : per-slot occupancy, for destination-register tracking
//   entry_addr   : per-slot destination register
module mips_wb_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                 CLK,
  input  logic                                 reset,
  input  logic                                 push,
  input  wb_req_t                              push_req,
  input  logic                                 pop,
  output wb_req_t                              head,
  output logic                                 full,
  output logic                                 empty,
  output logic [DEPTH-1:0]                     entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_addr
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  wb_req_t          mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [DEPTH-1:0] valid_q;

  logic do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr_q          <= rd_ptr_q + PtrW'(1);
        valid_q[rd_ptr_q] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: slots are only observed through valid_q.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_req;
    end
  end

  assign entry_valid = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/mips_wb_arbiter.sv
// Register-file write-port arbiter: sole writer of WriteAddress/RegWrite/DataIn.
// Merges the in-order pipeline result (fixed slot, always wins) with long-latency
// results buffered in a FIFO, and requests a pipeline bubble if the FIFO head keeps
// losing arbitration.
// Ports:
//   CLK, reset                  : clock (rising edge), asynchronous active-high reset
//   pri_valid/pri_addr/pri_data : pipeline result for this cycle
//   sec_valid/sec_ready         : long-latency handshake (sec_ready = FIFO not full)
//   sec_addr/sec_data           : long-latency result
//   stall_req                   : ask the pipeline for a bubble next cycle
//   WriteAddress/RegWrite/DataIn: registered register-file write port
//   pending_mask                : per-register "write still queued" bits
// Build option: define MIPS_WB_SCOREBOARD_EN to compute pending_mask from FIFO
// contents; otherwise pending_mask is constant zero.
module mips_wb_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  pri_valid,
  input  logic [REG_ADDR_W-1:0] pri_addr,
  input  logic [XLEN-1:0]       pri_data,
  input  logic                  sec_valid,
  output logic                  sec_ready,
  input  logic [REG_ADDR_W-1:0] sec_addr,
  input  logic [XLEN-1:0]       sec_data,
  output logic                  stall_req,
  output logic [REG_ADDR_W-1:0] WriteAddress,
  output logic                  RegWrite,
  output logic [XLEN-1:0]       DataIn,
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  wb_req_t                          push_req, head;
  logic                             fifo_full, fifo_empty;
  logic                             push, pop, pri_win, lose;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;

  // Zero-address results never write; secondary ones are still accepted.
  assign pri_win   = pri_valid && (pri_addr != '0);
  assign sec_ready = !fifo_full;
  assign push      = sec_valid && !fifo_full && (sec_addr != '0);
  // pop sees the registered empty flag, so a fresh push is never popped in its own cycle
  assign pop       = !pri_win && !fifo_empty;
  assign lose      = pri_win && !fifo_empty;

  assign push_req.addr = sec_addr;
  assign push_req.data = sec_data;

  mips_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .reset       (reset),
    .push        (push),
    .push_req    (push_req),
    .pop         (pop),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Write port
  logic [REG_ADDR_W-1:0] wa_q;
  logic                  rw_q;
  logic [XLEN-1:0]       di_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wa_q <= '0;
      rw_q <= 1'b0;
      di_q <= '0;
    end else if (pri_win) begin
      wa_q <= pri_addr;
      rw_q <= 1'b1;
      di_q <= pri_data;
    end else if (pop) begin
      wa_q <= head.addr;
      rw_q <= 1'b1;
      di_q <= head.data;
    end else begin
      rw_q <= 1'b0;
    end
  end

  assign WriteAddress = wa_q;
  assign RegWrite     = rw_q;
  assign DataIn       = di_q;

  // Starvation FSM: cnt_q counts consecutive lost cycles since leaving IDLE.
  wb_starve_state_t state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (lose) begin
          if (STARVE_LIMIT == 1) begin
            state_d = STALL;
          end else begin
            state_d = WAIT;
            cnt_d   = CntW'(1);
          end
        end
      end
      WAIT: begin
        if (lose) begin
          if (cnt_q == CntW'(STARVE_LIMIT - 1)) begin
            state_d = STALL;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          // head popped or FIFO drained
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      STALL: begin
        // a primary write during STALL is a pipeline protocol violation; keep asking
        if (!pri_win) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_req = (state_q == STALL);
  end

`ifdef MIPS_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] mask_d, mask_q;

  always_comb begin
    mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        mask_d[entry_addr[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign pending_mask = mask_q;
`else
  logic unused_sb;
  assign unused_sb    = ^{entry_valid, entry_addr};
  assign pending_mask = '0;
`endif

endmodule

// File: tb/tb_mips_wb_arbiter.sv
module tb_mips_wb_arbiter;
  import mips_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        CLK = 1'b0;
  logic        reset;
  logic        pri_valid;
  logic [4:0]  pri_addr;
  logic [31:0] pri_data;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_addr;
  logic [31:0] sec_data;
  logic        stall_req;
  logic [4:0]  WriteAddress;
  logic        RegWrite;
  logic [31:0] DataIn;
  logic [31:0] pending_mask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  mips_wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .pri_valid    (pri_valid),
    .pri_addr     (pri_addr),
    .pri_data     (pri_data),
    .sec_valid    (sec_valid),
    .sec_ready    (sec_ready),
    .sec_addr     (sec_addr),
    .sec_data     (sec_data),
    .stall_req    (stall_req),
    .WriteAddress (WriteAddress),
    .RegWrite     (RegWrite),
    .DataIn       (DataIn),
    .pending_mask (pending_mask)
  );

  // Reference model: a queue of pending writes plus a run-length of lost cycles.
  wb_req_t     mq[$];
  logic        m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_di;
  logic        m_stall;
  int          m_losses;
  logic [31:0] m_mask;

  task automatic model_reset();
    mq.delete();
    m_rw = 1'b0; m_wa = '0; m_di = '0;
    m_stall = 1'b0; m_losses = 0; m_mask = '0;
  endtask

  function automatic logic [71:0] obs_vec();
    return {RegWrite, WriteAddress, DataIn, stall_req, sec_ready, pending_mask};
  endfunction

  function automatic logic [71:0] exp_vec();
    logic rdy;
    rdy = (mq.size() < DEPTH);
    return {m_rw, m_wa, m_di, m_stall, rdy, m_mask};
  endfunction

  task automatic drive_idle();
    pri_valid = 0; pri_addr = 0; pri_data = 0;
    sec_valid = 0; sec_addr = 0; sec_data = 0;
  endtask

  // Apply inputs for one cycle, advance the model, and return at posedge + 1.
  task automatic cycle(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd);
    int      sz;
    logic    pw;
    wb_req_t e;
    pri_valid = pv; pri_addr = pa; pri_data = pd;
    sec_valid = sv; sec_addr = sa; sec_data = sd;
    sz = mq.size();
    pw = pv && (pa != 0);
    m_mask = '0;
`ifdef MIPS_WB_SCOREBOARD_EN
    foreach (mq[i]) m_mask[mq[i].addr] = 1'b1;
`endif
    if (pw) begin
      m_rw = 1'b1; m_wa = pa; m_di = pd;
    end else if (sz > 0) begin
      e = mq.pop_front();
      m_rw = 1'b1; m_wa = e.addr; m_di = e.data;
    end else begin
      m_rw = 1'b0;
    end
    if (sv && sz < DEPTH && sa != 0) begin
      e.addr = sa; e.data = sd;
      mq.push_back(e);
    end
    if (m_stall) begin
      if (!pw) begin m_stall = 1'b0; m_losses = 0; end
    end else if (pw && sz > 0) begin
      m_losses++;
      if (m_losses == STARVE_LIMIT) m_stall = 1'b1;
    end else begin
      m_losses = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_async: got %h exp %h", obs_vec(), exp_vec());
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    n_tests++;
    if (RegWrite !== 1'b0 || sec_ready !== 1'b1 || stall_req !== 1'b0 || DataIn !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release: got rw=%b rdy=%b st=%b di=%h exp rw=0 rdy=1 st=0 di=0",
               RegWrite, sec_ready, stall_req, DataIn);
    end
  endtask

  task automatic test_primary();
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    n_tests++;
    if (RegWrite !== 1'b1 || WriteAddress !== 5'd5 || DataIn !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL primary_write: got rw=%b wa=%0d di=%h exp rw=1 wa=5 di=deadbeef",
               RegWrite, WriteAddress, DataIn);
    end
    cycle(1, 5'd0, 32'h12345678, 0, 0, 0);
    n_tests++;
    if (RegWrite !== 1'b0 || WriteAddress !== 5'd5 || DataIn !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL primary_zero: got rw=%b wa=%0d di=%h exp rw=0 wa=5 di=deadbeef",
               RegWrite, WriteAddress, DataIn);
    end
  endtask

  task automatic test_sec_order();
    cycle(0, 0, 0, 1, 5'd3, 32'h11);
    n_tests++;
    if (RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL sec_latency: got rw=%b exp rw=0", RegWrite);
    end
    cycle(0, 0, 0, 1, 5'd4, 32'h22);
    n_tests++;
    if (RegWrite !== 1'b1 || WriteAddress !== 5'd3 || DataIn !== 32'h11) begin
      n_fail++;
      $display("FAIL sec_first: got rw=%b wa=%0d di=%h exp rw=1 wa=3 di=11",
               RegWrite, WriteAddress, DataIn);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sec_order c%0d: got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_starvation();
    int seen;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 5'd1 + 5'(i), $urandom, 1, 5'd10 + 5'(i), $urandom);
    end
    n_tests++;
    if (sec_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full_ready: got sec_ready=%b exp 0", sec_ready);
    end
    seen = -1;
    for (int c = 0; c < 20 && seen < 0; c++) begin
      cycle(1, 5'd7, $urandom, 1, 5'd20, $urandom);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL starve c%0d: got %h exp %h", c, obs_vec(), exp_vec());
      end
      if (stall_req === 1'b1) seen = c;
    end
    // 8th lost cycle happens on the 5th cycle after the FIFO became full
    n_tests++;
    if (seen != 4) begin
      n_fail++;
      $display("FAIL stall_timing: got first stall at extra cycle %0d exp 4", seen);
    end
    cycle(1, 5'd9, 32'hA5A5A5A5, 0, 0, 0);
    n_tests++;
    if (stall_req !== 1'b1 || WriteAddress !== 5'd9 || RegWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_violation: got st=%b wa=%0d rw=%b exp st=1 wa=9 rw=1",
               stall_req, WriteAddress, RegWrite);
    end
    cycle(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (stall_req !== 1'b0 || WriteAddress !== 5'd10 || RegWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_bubble: got st=%b wa=%0d rw=%b exp st=0 wa=10 rw=1",
               stall_req, WriteAddress, RegWrite);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL starve_drain c%0d: got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_push_pop();
    cycle(1, 5'd7, $urandom, 1, 5'd20, $urandom);
    cycle(1, 5'd8, $urandom, 1, 5'd21, $urandom);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 1, 5'd22 + 5'(i), $urandom);
      n_tests++;
      if (sec_ready !== 1'b1 || RegWrite !== 1'b1 || WriteAddress !== 5'd20 + 5'(i)
          || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL push_pop c%0d: got rdy=%b wa=%0d (%h) exp rdy=1 wa=%0d (%h)",
                 i, sec_ready, WriteAddress, obs_vec(), 20 + i, exp_vec());
      end
    end
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_vec() !== exp_vec() || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL push_pop_drain: got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_zero_addr();
    cycle(0, 0, 0, 1, 5'd0, 32'hBAD0BAD0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (RegWrite !== 1'b0 || pending_mask !== 32'h0 || sec_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL sec_zero c%0d: got rw=%b pm=%h rdy=%b exp rw=0 pm=0 rdy=1",
                 i, RegWrite, pending_mask, sec_ready);
      end
    end
  endtask

  task automatic test_random();
    logic pv;
    int   errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      if (m_stall && ($urandom % 8) != 0) pv = 1'b0;
      else pv = (($urandom % 3) != 0);
      cycle(pv, 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        errs++;
        if (errs < 10) $display("FAIL random c%0d: got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 5'd9, 32'h1, 1, 5'd11, 32'hB);
    cycle(1, 5'd9, 32'h2, 1, 5'd12, 32'hC);
    cycle(1, 5'd9, 32'h3, 1, 5'd13, 32'hD);
    n_tests++;
    if (RegWrite !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %h exp %h", obs_vec(), exp_vec());
    end
    drive_idle();
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (RegWrite !== 1'b0 || WriteAddress !== 5'd0 || DataIn !== 32'h0 ||
        stall_req !== 1'b0 || pending_mask !== 32'h0 || sec_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h exp rw=0 wa=0 di=0 st=0 rdy=1 pm=0", obs_vec());
    end
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (RegWrite !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_after c%0d: got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    model_reset();
    test_reset();
    test_primary();
    test_sec_order();
    test_starvation();
    test_push_pop();
    test_zero_addr();
    test_random();
    repeat (6) cycle(0, 0, 0, 0, 0, 0);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
